// File: rtl/vtiming_if.sv
// Bus bundle between the vertical timing generator and its surroundings.
// The master side drives line-advance and runtime configuration; the slave
// side (the timing generator) returns counter, sync, data-enable and events.
interface vtiming_if #(
  parameter int CNT_W   = 9,
  parameter int H_CNT_W = 10,
  parameter int FRAME_W = 8
);
  logic               en;
  logic [H_CNT_W-1:0] HsyncCount;
  logic               cfg_we;
  logic [CNT_W-1:0]   cfg_sync;
  logic [CNT_W-1:0]   cfg_bp;
  logic [CNT_W-1:0]   cfg_act;
  logic [CNT_W-1:0]   cfg_fp;

  logic [CNT_W-1:0]   VsyncCount;
  logic               Vsync;
  logic               vDE;
  logic [CNT_W-1:0]   active_line;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;
  logic               cfg_err;

  modport master (
    output en, HsyncCount, cfg_we, cfg_sync, cfg_bp, cfg_act, cfg_fp,
    input  VsyncCount, Vsync, vDE, active_line, frame_start, frame_cnt, cfg_err
  );

  modport slave (
    input  en, HsyncCount, cfg_we, cfg_sync, cfg_bp, cfg_act, cfg_fp,
    output VsyncCount, Vsync, vDE, active_line, frame_start, frame_cnt, cfg_err
  );
endinterface

// File: rtl/vtiming_gen.sv
// Parametrised vertical timing generator for the TFT-LCD panel path.
// Advances one line each time the horizontal counter reaches H_LAST, decodes
// sync/back-porch/active/front-porch regions, and swaps in a new line-count
// configuration only at the frame wrap so a frame is never torn.
module vtiming_gen #(
  parameter int CNT_W   = 9,
  parameter int H_CNT_W = 10,
  parameter int H_LAST  = 524,
  parameter int V_SYNC  = 10,
  parameter int V_BP    = 2,
  parameter int V_ACT   = 272,
  parameter int V_FP    = 2,
  parameter bit V_POL   = 1'b0,
  parameter int FRAME_W = 8
) (
  input  logic     clk,
  input  logic     rstn,
  vtiming_if.slave bus
);

  // Two extra bits so the sum of four CNT_W fields can never overflow.
  localparam int TW = CNT_W + 2;
  localparam logic [TW-1:0]      MAX_TOTAL = TW'(2 ** CNT_W);
  localparam logic [H_CNT_W-1:0] H_END     = H_CNT_W'(H_LAST);
  localparam logic [CNT_W-1:0]   DEF_SYNC  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0]   DEF_BP    = CNT_W'(V_BP);
  localparam logic [CNT_W-1:0]   DEF_ACT   = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0]   DEF_FP    = CNT_W'(V_FP);

  function automatic logic [TW-1:0] zext(input logic [CNT_W-1:0] v);
    return {2'b00, v};
  endfunction

  // Line counter and frame event state
  logic [CNT_W-1:0]   r_vCount;
  logic               r_vsync;
  logic               r_frameStart;
  logic [FRAME_W-1:0] r_frameCnt;

  // Active configuration (what the counter is using right now)
  logic [CNT_W-1:0]   r_curSync;
  logic [CNT_W-1:0]   r_curBp;
  logic [CNT_W-1:0]   r_curAct;
  logic [CNT_W-1:0]   r_curFp;

  // Pending configuration waiting for the next frame wrap
  logic [CNT_W-1:0]   r_pendSync;
  logic [CNT_W-1:0]   r_pendBp;
  logic [CNT_W-1:0]   r_pendAct;
  logic [CNT_W-1:0]   r_pendFp;
  logic               r_pendValid;
  logic               r_cfgErr;

  logic               w_adv;
  logic               w_wrap;
  logic [TW-1:0]      w_countExt;
  logic [TW-1:0]      w_total;
  logic [TW-1:0]      w_lastLine;
  logic [TW-1:0]      w_sbEnd;
  logic [TW-1:0]      w_actEnd;
  logic               w_inSync;
  logic               w_inAct;
  logic [CNT_W-1:0]   w_activeLine;
  logic [TW-1:0]      w_cfgSum;
  logic               w_cfgBad;

  assign w_adv      = bus.en && (bus.HsyncCount == H_END);
  assign w_countExt = zext(r_vCount);
  assign w_total    = zext(r_curSync) + zext(r_curBp) + zext(r_curAct) + zext(r_curFp);
  assign w_lastLine = w_total - TW'(1);
  // Using >= lets the counter recover if it is ever found beyond the frame end.
  assign w_wrap     = w_adv && (w_countExt >= w_lastLine);

  assign w_sbEnd    = zext(r_curSync) + zext(r_curBp);
  assign w_actEnd   = w_sbEnd + zext(r_curAct);
  assign w_inSync   = (w_countExt < zext(r_curSync));
  assign w_inAct    = (w_countExt >= w_sbEnd) && (w_countExt < w_actEnd);
  // Inside the active region sync+bp is below the count, so it fits CNT_W bits.
  assign w_activeLine = w_inAct ? (r_vCount - w_sbEnd[CNT_W-1:0]) : '0;

  assign w_cfgSum = zext(bus.cfg_sync) + zext(bus.cfg_bp) + zext(bus.cfg_act) + zext(bus.cfg_fp);
  assign w_cfgBad = (bus.cfg_sync == '0) || (bus.cfg_act == '0) || (w_cfgSum > MAX_TOTAL);

  // Line counter, frame-start pulse and frame counter advance on the falling edge.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vCount     <= '0;
      r_frameStart <= 1'b0;
      r_frameCnt   <= '0;
    end else begin
      r_frameStart <= w_wrap;
      if (w_wrap) begin
        r_vCount   <= '0;
        r_frameCnt <= r_frameCnt + 1'b1;
      end else if (w_adv) begin
        r_vCount   <= r_vCount + 1'b1;
      end
    end
  end

  // Vsync follows the sync region one clock late to match legacy panel timing.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vsync <= V_POL;
    end else begin
      r_vsync <= w_inSync ? V_POL : ~V_POL;
    end
  end

  // Config shadow: validate and capture writes, promote pending at frame wrap.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      r_curSync   <= DEF_SYNC;
      r_curBp     <= DEF_BP;
      r_curAct    <= DEF_ACT;
      r_curFp     <= DEF_FP;
      r_pendSync  <= DEF_SYNC;
      r_pendBp    <= DEF_BP;
      r_pendAct   <= DEF_ACT;
      r_pendFp    <= DEF_FP;
      r_pendValid <= 1'b0;
      r_cfgErr    <= 1'b0;
    end else begin
      r_cfgErr <= 1'b0;
      if (w_wrap && r_pendValid) begin
        r_curSync   <= r_pendSync;
        r_curBp     <= r_pendBp;
        r_curAct    <= r_pendAct;
        r_curFp     <= r_pendFp;
        r_pendValid <= 1'b0;
      end
      // A write landing on the wrap clock is held for the following wrap;
      // being later in this block, its valid flag overrides the clear above.
      if (bus.cfg_we) begin
        if (w_cfgBad) begin
          r_cfgErr <= 1'b1;
        end else begin
          r_pendSync  <= bus.cfg_sync;
          r_pendBp    <= bus.cfg_bp;
          r_pendAct   <= bus.cfg_act;
          r_pendFp    <= bus.cfg_fp;
          r_pendValid <= 1'b1;
        end
      end
    end
  end

  assign bus.VsyncCount  = r_vCount;
  assign bus.Vsync       = r_vsync;
  assign bus.vDE         = w_inAct;
  assign bus.active_line = w_activeLine;
  assign bus.frame_start = r_frameStart;
  assign bus.frame_cnt   = r_frameCnt;
  assign bus.cfg_err     = r_cfgErr;

endmodule

// File: tb/tb_vtiming_gen.sv
// Self-checking bench for vtiming_gen. The stimulus process keeps a small
// behavioural model and pushes the expected state of every line advance and
// every rejected config write into queues; a monitor pops and compares when
// the DUT shows a new line or a cfg_err pulse. Frame-level results are also
// compared against hand-computed constants.
module tb_vtiming_gen;

  localparam int CNT_W   = 9;
  localparam int H_CNT_W = 10;
  localparam int H_LAST  = 524;
  localparam int FRAME_W = 8;
  localparam bit V_POL   = 1'b0;
  localparam int D_SYNC  = 10;
  localparam int D_BP    = 2;
  localparam int D_ACT   = 272;
  localparam int D_FP    = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  vtiming_if #(.CNT_W(CNT_W), .H_CNT_W(H_CNT_W), .FRAME_W(FRAME_W)) bus();

  vtiming_gen #(
    .CNT_W(CNT_W), .H_CNT_W(H_CNT_W), .H_LAST(H_LAST),
    .V_SYNC(D_SYNC), .V_BP(D_BP), .V_ACT(D_ACT), .V_FP(D_FP),
    .V_POL(V_POL), .FRAME_W(FRAME_W)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // Pixel clock, DUT is active on the falling edge.
  initial forever #5 clk = ~clk;

  typedef struct {
    int cnt;
    int de;
    int aline;
    int vs;
    int fc;
    int fs;
  } lineExp_t;

  lineExp_t lineQ[$];
  int       errQ[$];
  lineExp_t expL;
  int       expErr;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int mSync, mBp, mAct, mFp;
  int pSync, pBp, pAct, pFp, pValid;
  int mCount, mFrame, mWraps;

  // Monitor bookkeeping
  int prevSeen = 0;
  int linesSinceFs = 0, deSinceFs = 0, syncSinceFs = 0;
  int lastLen = 0, lastDe = 0, lastSync = 0;
  int fsSeen = 0, errSeen = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mSync = D_SYNC; mBp = D_BP; mAct = D_ACT; mFp = D_FP;
    pSync = D_SYNC; pBp = D_BP; pAct = D_ACT; pFp = D_FP;
    pValid = 0; mCount = 0; mFrame = 0;
  endtask

  // Model reaction to one falling edge with the given inputs.
  task automatic modelEdge(input int h, input int e, input int we);
    int adv, wrap, oldVs, tot, de, aline, sum;
    adv   = (e != 0 && h == H_LAST) ? 1 : 0;
    tot   = mSync + mBp + mAct + mFp;
    wrap  = (adv != 0 && mCount == tot - 1) ? 1 : 0;
    oldVs = (mCount < mSync) ? int'(V_POL) : int'(!V_POL);
    if (adv != 0) begin
      if (wrap != 0) begin
        mCount = 0;
        mFrame = (mFrame + 1) % (1 << FRAME_W);
        mWraps++;
        if (pValid != 0) begin
          mSync = pSync; mBp = pBp; mAct = pAct; mFp = pFp;
          pValid = 0;
        end
      end else begin
        mCount++;
      end
    end
    if (we != 0) begin
      sum = int'(bus.cfg_sync) + int'(bus.cfg_bp) + int'(bus.cfg_act) + int'(bus.cfg_fp);
      if (bus.cfg_sync == 0 || bus.cfg_act == 0 || sum > (1 << CNT_W)) begin
        errQ.push_back(mCount);
      end else begin
        pSync = int'(bus.cfg_sync); pBp = int'(bus.cfg_bp);
        pAct  = int'(bus.cfg_act);  pFp = int'(bus.cfg_fp);
        pValid = 1;
      end
    end
    if (adv != 0) begin
      de    = (mCount >= mSync + mBp && mCount < mSync + mBp + mAct) ? 1 : 0;
      aline = (de != 0) ? mCount - (mSync + mBp) : 0;
      lineQ.push_back('{mCount, de, aline, oldVs, mFrame, wrap});
    end
  endtask

  task automatic applyStimulus(input int h, input int e, input int we);
    bus.HsyncCount = H_CNT_W'(h);
    bus.en         = (e != 0);
    bus.cfg_we     = (we != 0);
    @(negedge clk);
    modelEdge(h, e, we);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic runLines(input int n);
    repeat (n) begin
      applyStimulus(0, 1, 0);
      applyStimulus(H_LAST, 1, 0);
    end
  endtask

  task automatic setCfg(input int s, input int b, input int a, input int f);
    bus.cfg_sync = CNT_W'(s);
    bus.cfg_bp   = CNT_W'(b);
    bus.cfg_act  = CNT_W'(a);
    bus.cfg_fp   = CNT_W'(f);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFrame(input string tag, input int len, input int de, input int sy, input int fc);
    checkOutput({tag, "_frame_len"}, lastLen, len);
    checkOutput({tag, "_de_lines"}, lastDe, de);
    checkOutput({tag, "_sync_lines"}, lastSync, sy);
    checkOutput({tag, "_frame_cnt"}, int'(bus.frame_cnt), fc);
  endtask

  // Monitor: compare on every new line and every cfg_err pulse.
  always @(posedge clk) begin
    if (!rstn) begin
      prevSeen     = int'(bus.VsyncCount);
      linesSinceFs = 0;
      deSinceFs    = 0;
      syncSinceFs  = 0;
    end else begin
      if (bus.cfg_err) begin
        errSeen++;
        if (errQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL cfg_err_unexpected: got pulse at line %0d, expected none", bus.VsyncCount);
        end else begin
          expErr = errQ.pop_front();
          checkOutput("cfg_err_line", int'(bus.VsyncCount), expErr);
        end
      end
      if (bus.frame_start) fsSeen++;
      if (int'(bus.VsyncCount) != prevSeen) begin
        prevSeen = int'(bus.VsyncCount);
        if (lineQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL line_unexpected: got line %0d, expected no advance", bus.VsyncCount);
        end else begin
          expL = lineQ.pop_front();
          checkOutput("VsyncCount", int'(bus.VsyncCount), expL.cnt);
          checkOutput("vDE", int'(bus.vDE), expL.de);
          checkOutput("active_line", int'(bus.active_line), expL.aline);
          checkOutput("Vsync_lag", int'(bus.Vsync), expL.vs);
          checkOutput("frame_cnt", int'(bus.frame_cnt), expL.fc);
          checkOutput("frame_start", int'(bus.frame_start), expL.fs);
        end
        linesSinceFs++;
        if (bus.vDE) deSinceFs++;
        if (bus.Vsync == V_POL) syncSinceFs++;
        if (bus.frame_start) begin
          lastLen = linesSinceFs;
          lastDe  = deSinceFs;
          lastSync = syncSinceFs;
          linesSinceFs = 0;
          deSinceFs    = 0;
          syncSinceFs  = 0;
        end
      end
    end
  end

  // Watchdog so a stuck design still produces a verdict.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.en = 1'b0;
    bus.HsyncCount = '0;
    bus.cfg_we = 1'b0;
    setCfg(0, 0, 0, 0);
    mWraps = 0;
    modelReset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rstn = 1'b1;
    settle();

    // Reset state
    checkOutput("rst_VsyncCount", int'(bus.VsyncCount), 0);
    checkOutput("rst_Vsync", int'(bus.Vsync), int'(V_POL));
    checkOutput("rst_active_line", int'(bus.active_line), 0);
    checkOutput("rst_frame_start", int'(bus.frame_start), 0);
    checkOutput("rst_frame_cnt", int'(bus.frame_cnt), 0);
    checkOutput("rst_cfg_err", int'(bus.cfg_err), 0);

    // Defaults: one full horizontal sweep advances exactly one line
    for (int h = 0; h <= H_LAST; h++) applyStimulus(h, 1, 0);
    settle();
    checkOutput("sweep_one_advance", int'(bus.VsyncCount), 1);
    runLines(285);
    settle();
    checkOutput("t1_wrapped_to_zero", int'(bus.VsyncCount), 0);
    checkFrame("t1", 286, 272, 10, 1);

    // en low with HsyncCount at the line end holds everything
    runLines(50);
    repeat (5) begin
      applyStimulus(0, 0, 0);
      applyStimulus(H_LAST, 0, 0);
    end
    settle();
    checkOutput("t2_count_hold", int'(bus.VsyncCount), 50);
    checkOutput("t2_no_frame_start", fsSeen, 1);
    checkOutput("t2_frame_cnt_hold", int'(bus.frame_cnt), 1);

    // Runtime config at line 100 takes effect only on the next frame
    runLines(50);
    setCfg(4, 3, 8, 1);
    applyStimulus(0, 1, 1);
    runLines(186);
    settle();
    checkOutput("t3_old_frame_len", lastLen, 286);
    runLines(16);
    settle();
    checkFrame("t3_new", 16, 8, 4, 3);

    // Config write on the wrap clock waits one more frame
    runLines(15);
    setCfg(4, 3, 20, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(H_LAST, 1, 1);
    settle();
    checkOutput("t4_wrap_frame_len", lastLen, 16);
    runLines(16);
    settle();
    checkFrame("t4_kept_old", 16, 8, 4, 5);
    runLines(28);
    settle();
    checkFrame("t4_applied", 28, 20, 4, 6);

    // Rejected writes pulse cfg_err and leave pending alone; sum of 512 is legal
    runLines(5);
    setCfg(100, 10, 397, 5);
    applyStimulus(0, 1, 1);
    setCfg(0, 2, 8, 2);
    applyStimulus(0, 1, 1);
    setCfg(4, 3, 0, 1);
    applyStimulus(0, 1, 1);
    setCfg(100, 10, 400, 5);
    applyStimulus(0, 1, 1);
    settle();
    checkOutput("t5_err_pulses", errSeen, 3);
    runLines(23);
    settle();
    checkOutput("t5_unchanged_frame_len", lastLen, 28);
    runLines(512);
    settle();
    checkFrame("t5_max", 512, 397, 100, 8);

    // Asynchronous reset mid-frame restores defaults
    runLines(150);
    settle();
    rstn = 1'b0;
    modelReset();
    #1;
    checkOutput("t6_rst_count", int'(bus.VsyncCount), 0);
    checkOutput("t6_rst_frame_cnt", int'(bus.frame_cnt), 0);
    checkOutput("t6_rst_Vsync", int'(bus.Vsync), int'(V_POL));
    checkOutput("t6_rst_vDE", int'(bus.vDE), 0);
    repeat (3) @(negedge clk);
    #1;
    rstn = 1'b1;
    runLines(286);
    settle();
    checkFrame("t6_defaults", 286, 272, 10, 1);

    // Everything expected was actually observed
    checkOutput("lines_pending", lineQ.size(), 0);
    checkOutput("errs_pending", errQ.size(), 0);
    checkOutput("frame_start_total", fsSeen, mWraps);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vtiming_gen.md
Name: vtiming_gen

Overview:
- Parametrised vertical timing generator for the TFT-LCD panel path.
- Successor to the fixed 286-line vertical counter. Sync, back-porch, active and front-porch lengths become parameters, with runtime overrides applied only at a frame boundary.
- Also adds an enable, output polarity control, an active-line index, a frame-start pulse and a frame counter.
- Driven by the horizontal counter of the horizontal timing block; feeds the pixel/DE mux and the frame-buffer read controller.

Parameters:
- CNT_W, 9, width of vertical counter and line fields
- H_CNT_W, 10, width of HsyncCount input
- H_LAST, 524, HsyncCount value that ends a line (line-advance point)
- V_SYNC, 10, default sync lines
- V_BP, 2, default back-porch lines
- V_ACT, 272, default active lines
- V_FP, 2, default front-porch lines
- V_POL, 0, asserted level of Vsync (0 = active-low)
- FRAME_W, 8, frame counter width

Ports:
- clk  in  1  pixel clock; all registers update on falling edge
- rstn  in  1  async active-low reset
- en  in  1  line-advance enable
- HsyncCount  in  H_CNT_W  horizontal counter
- cfg_we  in  1  one-cycle strobe, capture cfg_* into pending shadow
- cfg_sync, cfg_bp, cfg_act, cfg_fp  in  CNT_W each  requested line counts
- VsyncCount  out  CNT_W  current line, 0..total-1
- Vsync  out  1  vertical sync, polarity V_POL
- vDE  out  1  vertical data-enable
- active_line  out  CNT_W  line index within active region
- frame_start  out  1  one-clk pulse at frame wrap
- frame_cnt  out  FRAME_W  frames completed, wraps
- cfg_err  out  1  one-clk pulse, cfg rejected

Behaviour:

Reset:
- VsyncCount = 0, Vsync = V_POL, active_line = 0, frame_start = 0, frame_cnt = 0, cfg_err = 0.
- Active cfg = parameter defaults; pending-valid flag = 0.

Line advance:
- adv = en && (HsyncCount == H_LAST).
- On adv: VsyncCount increments if < total-1, else wraps to 0.
- When adv is false, VsyncCount holds.
- total = sync + bp + act + fp, computed at CNT_W+2 bits.

Region decode (combinational on VsyncCount and active cfg):
- SYNC: count < s.
- BP: s ≤ count < s+bp.
- ACTIVE: s+bp ≤ count < s+bp+act.
- FP: the remainder.

Outputs:
- vDE: combinational, 1 in ACTIVE.
- active_line: combinational, count−(s+bp) in ACTIVE, else 0.
- Vsync: registered. Next value is V_POL when the current count is in SYNC, else ~V_POL. This gives one clk lag behind VsyncCount, for legacy timing compatibility.

Frame events:
- frame_start: registered; 1 for exactly the clk in which VsyncCount becomes 0 by wrap. Not asserted by reset or while en = 0.
- frame_cnt: increments on the same wrap, modulo 2^FRAME_W.

Config shadow:
- cfg_we copies cfg_* into pending and sets pending-valid. A later cfg_we overwrites pending (last write wins).
- Reject if any of the following holds: cfg_sync == 0, cfg_act == 0, or sum > 2^CNT_W. On reject: cfg_err pulses the next clk, and pending and pending-valid are unchanged.
- On wrap with pending-valid: active cfg ← pending, pending-valid ← 0. New timing is effective from line 0 of the new frame.
- cfg_we in the same clk as a wrap is captured into pending and applied at the following wrap, not the current one.
- No mid-frame change to active cfg ever occurs.

Other rules:
- bp = 0 or fp = 0 is legal; the corresponding region is empty.
- Reset mid-frame: all state returns to reset values immediately (async), and defaults are restored. Counting resumes from line 0 on the first adv after rstn deasserts.
- en = 0: count, Vsync and frame_cnt hold; cfg capture still operates.

Test Plan:
1. Defaults, en = 1, HsyncCount sweeps 0..524.
   - Count runs 0..285 and wraps.
   - vDE = 1 for lines 12..283; Vsync low one clk after the count enters 0..9.
   - frame_start pulses once per 286 lines; frame_cnt increments.
2. Drive HsyncCount = 524 with en = 0 for 5 lines mid-frame.
   - VsyncCount holds, and no frame_start.
3. At line 100, cfg_we with sync=4, bp=3, act=8, fp=1.
   - Current frame keeps 286 lines.
   - Next frame: total 16, vDE on lines 7..14, active_line 0..7.
4. cfg_we asserted in the exact wrap clk with act=20.
   - The frame just starting keeps the old timing; the next frame has act=20.
5. cfg_we with cfg_sync = 0, then cfg_act = 400 (sum > 512).
   - cfg_err pulses once per write; timing unchanged.
6. rstn pulled low at line 150 for 3 clks.
   - Count = 0, frame_cnt = 0, Vsync = V_POL, defaults restored.
   - Normal 286-line cycle resumes.
